serial_divider: RTL and testbench

- Iterative restoring divider for the RV32M divide and remainder group: DIV, DIVU, REM, REMU.
- Companion to the MAC-based multiplier; it is the inverse-operation half of the multdiv unit.
- Produces one quotient bit per cycle, then applies a sign fix-up.
- Accepts one operation at a time through a valid/ready handshake; the result is presented with a one-cycle valid pulse.

---
 rtl/serial_divider.sv | 136 +++++++++++++
 tb/tb_serial_divider.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_divider.sv
// serial_divider: iterative restoring divider for DIV, DIVU, REM and REMU.
// Produces one quotient bit per cycle on operand magnitudes, then a FIX cycle
// restores the signs. Divide-by-zero and signed overflow are resolved at
// accept time and go straight to DONE.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset
//   valid_i   request valid; accepted when ready_o is high
//   ready_o   high in IDLE
//   op_i      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   op_a_i    dividend
//   op_b_i    divisor
//   kill_i    abort the operation in flight (ignored in IDLE)
//   busy_o    high whenever not IDLE
//   valid_o   one-cycle result pulse (in DONE, suppressed by kill_i)
//   result_o  quotient or remainder; holds until the next result is written
module serial_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic             kill_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, b_mag_q;
   logic             neg_q_q, neg_r_q, is_rem_q;

   // Request decode (only meaningful in IDLE)
   logic             sgn, a_neg, b_neg, div0, ovf;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign sgn   = ~op_i[0];
   assign a_neg = sgn & op_a_i[WIDTH-1];
   assign b_neg = sgn & op_b_i[WIDTH-1];
   // Magnitude of the most-negative value comes out as unsigned 2^(WIDTH-1).
   assign a_mag = a_neg ? (~op_a_i + 1'b1) : op_a_i;
   assign b_mag = b_neg ? (~op_b_i + 1'b1) : op_b_i;
   assign div0  = (op_b_i == '0);
   assign ovf   = sgn & (op_a_i == MOST_NEG) & (op_b_i == '1);

   // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
   // The extra bit of trial is the borrow, i.e. "shifted < divisor".
   logic [WIDTH:0]   shifted, trial;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, b_mag_q};
   assign quo_fix = neg_q_q ? (~quo_q + 1'b1) : quo_q;
   assign rem_fix = neg_r_q ? (~rem_q + 1'b1) : rem_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ready_o = 1'b0;
      busy_o  = 1'b1;
      valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            busy_o  = 1'b0;
            if (valid_i) state_d = (div0 | ovf) ? DONE : ITER;
         end
         ITER: begin
            if (kill_i)            state_d = IDLE;
            else if (cnt_q == '0)  state_d = FIX;
         end
         FIX:  state_d = kill_i ? IDLE : DONE;
         DONE: begin
            valid_o = ~kill_i;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         b_mag_q  <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         is_rem_q <= 1'b0;
         result_o <= '0;
      end else begin
         case (state_q)
            IDLE: if (valid_i) begin
               is_rem_q <= op_i[1];
               neg_q_q  <= a_neg ^ b_neg;
               neg_r_q  <= a_neg;
               b_mag_q  <= b_mag;
               rem_q    <= '0;
               quo_q    <= a_mag;
               cnt_q    <= CW'(WIDTH - 1);
               // Divide-by-zero is tested first so it wins over overflow.
               if (div0)     result_o <= op_i[1] ? op_a_i : '1;
               else if (ovf) result_o <= op_i[1] ? '0 : MOST_NEG;
            end
            ITER: begin
               if (!trial[WIDTH]) begin
                  rem_q <= trial[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_q <= shifted[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt_q <= cnt_q - 1'b1;
            end
            FIX: if (!kill_i) result_o <= is_rem_q ? rem_fix : quo_fix;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_divider.sv
// Bench for serial_divider: table of directed vectors plus random ops checked
// through an expected-result queue, and hand sequences for kill, reset and
// the DONE-cycle handshake.
module tb_serial_divider;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_i, valid_i, kill_i;
   logic         ready_o, busy_o, valid_o;
   logic [1:0]   op_i;
   logic [W-1:0] op_a_i, op_b_i, result_o;

   serial_divider #(.WIDTH(W)) dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .op_i(op_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .kill_i(kill_i),
      .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a, b, res;
      int           lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      int           lat;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[15];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] q, r;
      if (b == 0) return op[1] ? a : '1;
      if (!op[0] && a == 32'h8000_0000 && b == '1) return op[1] ? '0 : 32'h8000_0000;
      if (!op[0]) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == 0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == '1) return 1;
      return W + 2;
   endfunction

   // Issue one request, then wait (bounded) for valid_o and compare against
   // the queue head. Latency is counted in cycles with the accepting edge as 1.
   task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] res, input int lat);
      exp_t e;
      bit   seen;
      int   n;
      n = 0;
      while (!ready_o && n < 10) begin @(negedge clk); n++; end
      sb.push_back('{res, lat});
      op_i = op; op_a_i = a; op_b_i = b; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      op_a_i = $urandom; op_b_i = $urandom; op_i = 2'($urandom);
      seen = 1'b0;
      for (int c = 1; c <= 60 && !seen; c++) begin
         @(negedge clk);
         if (valid_o) begin
            seen = 1'b1;
            e = sb.pop_front();
            chk({name, " result"}, result_o, e.res);
            chk({name, " latency"}, W'(c), W'(e.lat));
         end
      end
      if (!seen) begin
         n_vec++; n_err++;
         void'(sb.pop_front());
         $display("FAIL %s: timeout, no valid_o within 60 cycles", name);
      end else begin
         @(negedge clk);
         chk({name, " pulse"}, {31'd0, valid_o}, 32'd0);
      end
   endtask

   task automatic watch_quiet(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (valid_o) seen = 1'b1;
      end
      chk(name, {31'd0, seen}, 32'd0);
   endtask

   initial begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      bit           seen;

      tbl[0]  = '{2'd0, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
      tbl[1]  = '{2'd2, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 34};
      tbl[2]  = '{2'd1, 32'hFFFF_FFFF,  32'h0000_0010, 32'h0FFF_FFFF, 34};
      tbl[3]  = '{2'd3, 32'hFFFF_FFFF,  32'h0000_0010, 32'h0000_000F, 34};
      tbl[4]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
      tbl[5]  = '{2'd0, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
      tbl[6]  = '{2'd3, 32'd5,          32'd0,         32'h0000_0005, 1};
      tbl[7]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
      tbl[8]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
      tbl[9]  = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 34};
      tbl[10] = '{2'd0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
      tbl[11] = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34};
      tbl[12] = '{2'd0, 32'h8000_0000,  32'd1,         32'h8000_0000, 34};
      tbl[13] = '{2'd2, 32'h8000_0000,  32'd0,         32'h8000_0000, 1};
      tbl[14] = '{2'd1, 32'd100,        32'd7,         32'h0000_000E, 34};

      rst_i = 1'b1; valid_i = 1'b0; kill_i = 1'b0;
      op_i = 2'd0; op_a_i = '0; op_b_i = '0;
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      chk("reset ready", {31'd0, ready_o}, 32'd1);
      chk("reset busy",  {31'd0, busy_o},  32'd0);
      chk("reset valid", {31'd0, valid_o}, 32'd0);
      chk("reset result", result_o, 32'd0);

      foreach (tbl[i])
         run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);

      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom >> $urandom_range(0, 31);
         if (rb == 0) rb = 32'd3;
         run_op($sformatf("rnd%0d", i), rop, ra, rb, ref_res(rop, ra, rb), ref_lat(rop, ra, rb));
      end

      // kill in ITER at cycle 10, then the same op runs to completion
      op_i = 2'd1; op_a_i = 32'd100; op_b_i = 32'd7; valid_i = 1'b1;
      @(posedge clk); #1 valid_i = 1'b0;
      repeat (8) @(posedge clk);
      #1 kill_i = 1'b1;
      @(posedge clk); #1 kill_i = 1'b0;
      @(negedge clk);
      chk("kill ready", {31'd0, ready_o}, 32'd1);
      chk("kill busy",  {31'd0, busy_o},  32'd0);
      watch_quiet("kill no valid", 40);
      run_op("after kill", 2'd1, 32'd100, 32'd7, 32'h0000_000E, 34);

      // synchronous reset mid-operation (result_o is nonzero beforehand)
      op_i = 2'd0; op_a_i = 32'd1000; op_b_i = 32'hFFFF_FFFD; valid_i = 1'b1;
      @(posedge clk); #1 valid_i = 1'b0;
      repeat (18) @(posedge clk);
      #1 rst_i = 1'b1;
      @(posedge clk); #1 rst_i = 1'b0;
      @(negedge clk);
      chk("rst ready",  {31'd0, ready_o}, 32'd1);
      chk("rst busy",   {31'd0, busy_o},  32'd0);
      chk("rst valid",  {31'd0, valid_o}, 32'd0);
      chk("rst result", result_o, 32'd0);
      watch_quiet("rst no valid", 40);

      // valid_i held through DONE: second request taken only in next IDLE
      op_i = 2'd0; op_a_i = 32'd5; op_b_i = 32'd0; valid_i = 1'b1;
      @(posedge clk); #1;
      op_i = 2'd3; op_a_i = 32'd9;
      @(negedge clk);
      chk("hold done valid",  {31'd0, valid_o}, 32'd1);
      chk("hold done ready",  {31'd0, ready_o}, 32'd0);
      chk("hold first result", result_o, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("hold idle ready", {31'd0, ready_o}, 32'd1);
      chk("hold idle valid", {31'd0, valid_o}, 32'd0);
      @(posedge clk); #1 valid_i = 1'b0;
      @(negedge clk);
      chk("hold second valid",  {31'd0, valid_o}, 32'd1);
      chk("hold second result", result_o, 32'd9);

      // kill during DONE suppresses the pulse
      @(negedge clk);
      op_i = 2'd0; op_a_i = 32'd5; op_b_i = 32'd0; valid_i = 1'b1;
      @(posedge clk); #1 valid_i = 1'b0; kill_i = 1'b1;
      @(negedge clk);
      chk("kill done valid", {31'd0, valid_o}, 32'd0);
      @(posedge clk); #1 kill_i = 1'b0;
      @(negedge clk);
      chk("kill done ready", {31'd0, ready_o}, 32'd1);

      // valid_i with kill_i in IDLE is still accepted
      op_i = 2'd1; op_a_i = 32'd100; op_b_i = 32'd7; valid_i = 1'b1; kill_i = 1'b1;
      @(posedge clk); #1 valid_i = 1'b0; kill_i = 1'b0;
      @(negedge clk);
      chk("idle kill accepted", {31'd0, busy_o}, 32'd1);
      seen = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         if (valid_o) seen = 1'b1;
      end
      chk("idle kill done", {31'd0, seen}, 32'd1);
      chk("idle kill result", result_o, 32'h0000_000E);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
